stack_ctrl_mc: RTL and testbench
================================

Name: stack_ctrl_mc

Overview:
Parametrised multicycle control unit for the 8-opcode stack-machine datapath. It adds a DECODE state so branching uses the freshly written IR, and a mem_ready wait handshake on every memory access. It also tracks stack occupancy with optional over/underflow trapping. It sits between IR/opcode decode and the datapath strobes (PC, IR, MDR, A/B, ALU, stack, memory).

Parameters:
DATA_W, 8, width of tos input
STACK_DEPTH, 8, stack capacity in entries (>=2)
DEPTH_W, $clog2(STACK_DEPTH+1), width of sp_depth (derived localparam, not overridable)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
opcode  in  3  IR[opcode]: 000 add, 001 sub, 010 and, 011 not, 100 push, 101 pop, 110 jz, 111 jmp
tos  in  DATA_W  current top-of-stack value (jz test)
mem_ready  in  1  memory completes the current mem_read/mem_write this cycle
mem_read  out  1  memory read request, held until mem_ready
mem_write  out  1  memory write request, held until mem_ready
addr_src  out  1  0=PC, 1=IR address
ir_write  out  1  load IR
pc_write  out  1  load PC (increment or jump target)
jump  out  1  PC mux selects IR address
mdr_en  out  1  load MDR
load_a  out  1  load A from stack pop
load_b  out  1  load B from stack pop
alu_control  out  2  opcode[1:0] during EXEC
push  out  1  stack push
pop  out  1  stack pop
stack_src  out  1  0=ALU, 1=MDR
sp_depth  out  DEPTH_W  current stack occupancy
instr_done  out  1  one-cycle pulse in an instruction's last cycle
fault  out  1  sticky stack-fault flag

Behaviour:
- Reset (async, reset_n=0): state=FETCH, sp_depth=0, fault=0.
- All strobes are combinational from state (Moore), except: memory completion qualified by mem_ready; jump/pc_write in JUMP qualified by the zero test.
- Default for every output in every state is 0.
- FETCH:
  - mem_read=1, addr_src=0.
  - While mem_ready=0, stay with no other strobes.
  - On mem_ready=1: ir_write=1, pc_write=1, next DECODE.
- DECODE: no strobes. Runs the guard check (optional feature). Next state by opcode:
  - 0xx, except 011 -> LOAD_A
  - 011 -> LOAD_A
  - 100 -> LOAD_MDR
  - 101 -> POP_WR
  - 11x -> JUMP
- LOAD_A: pop=1, load_a=1. Next NOT_EX if opcode==011, else LOAD_B.
- LOAD_B: pop=1, load_b=1. Next OP2.
- OP2: push=1, stack_src=0, alu_control=opcode[1:0], instr_done=1. Next FETCH.
- NOT_EX: push=1, stack_src=0, alu_control=2'b11, instr_done=1. Next FETCH.
- JUMP: take = opcode[0] | (tos=={DATA_W{1'b0}}).
  - jump=take, pc_write=take, instr_done=1. Next FETCH.
  - No pop on jz.
- POP_WR:
  - mem_write=1, addr_src=1. Wait while mem_ready=0.
  - On mem_ready: pop=1, instr_done=1, next FETCH. pop is asserted exactly once.
- LOAD_MDR:
  - mem_read=1, addr_src=1. Wait while mem_ready=0.
  - On mem_ready: mdr_en=1, next PUSH_MDR.
- PUSH_MDR: push=1, stack_src=1, instr_done=1. Next FETCH.
- sp_depth: +1 on every push cycle, -1 on every pop cycle. Push and pop never coincide.
- Latency with mem_ready tied 1, FETCH to instr_done inclusive:
  - ALU2 5 cycles, NOT 4, push 4, pop 3, jmp/jz 3.
- Reset mid-operation (including mid-wait) aborts immediately. Outputs drop to 0 asynchronously.

Optional Feature:
Macro STACK_GUARD_EN.
- Defined: DECODE checks the requirement for the decoded opcode:
  - ALU2: sp_depth>=2
  - not/pop/jz: sp_depth>=1
  - push: sp_depth<STACK_DEPTH
  - jmp: none
- On violation: enter FAULT (no strobes, fault=1). FAULT is terminal until reset_n asserted.
- Undefined: no check, FAULT state absent, fault tied 0. sp_depth saturates at 0 and STACK_DEPTH instead of wrapping.

Test Plan:
- Reset then mem_ready=1, program push,push,add (opcode 100,100,000) -> push at cycles 4 and 8, pops at LOAD_A/LOAD_B, OP2 alu_control=00; sp_depth 0->1->2->0->1.
- FETCH with mem_ready low 3 cycles -> mem_read=1, addr_src=0 held 4 cycles; ir_write/pc_write single pulse on the 4th.
- jz (110) with tos=8'h00 -> jump=pc_write=1 in JUMP; tos=8'h05 -> both 0, instr_done=1, next FETCH.
- pop (101) with mem_ready low 2 cycles -> mem_write held 3 cycles, pop=1 exactly once, sp_depth decrements by 1.
- STACK_GUARD_EN, sp_depth=1, opcode 001 -> DECODE goes to FAULT, fault=1, no pop; stays until reset_n=0, which clears fault.
- reset_n pulled low during LOAD_MDR wait -> all outputs 0 immediately; after release, state FETCH, sp_depth=0.

Source files
------------

// File: rtl/stack_ctrl_mc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// stack_ctrl_mc : multicycle controller for the 8-opcode stack machine, with
// mem_ready handshaking and stack occupancy tracking. Macro STACK_GUARD_EN
// enables a DECODE-time over/underflow trap into a terminal FAULT state.
// Revision: 1.0
// ============================================================================
module stack_ctrl_mc #(
  parameter  int DATA_W      = 8,
  parameter  int STACK_DEPTH = 8,
  localparam int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2:0]         opcode,
  input  logic [DATA_W-1:0]  tos,
  input  logic               mem_ready,
  output logic               mem_read,
  output logic               mem_write,
  output logic               addr_src,
  output logic               ir_write,
  output logic               pc_write,
  output logic               jump,
  output logic               mdr_en,
  output logic               load_a,
  output logic               load_b,
  output logic [1:0]         alu_control,
  output logic               push,
  output logic               pop,
  output logic               stack_src,
  output logic [DEPTH_W-1:0] sp_depth,
  output logic               instr_done,
  output logic               fault
);

  localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(STACK_DEPTH);
  localparam logic [DEPTH_W-1:0] DEPTH_ONE  = DEPTH_W'(1);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_LOAD_A   = 4'd2,
    S_LOAD_B   = 4'd3,
    S_OP2      = 4'd4,
    S_NOT_EX   = 4'd5,
    S_JUMP     = 4'd6,
    S_POP_WR   = 4'd7,
    S_LOAD_MDR = 4'd8,
`ifdef STACK_GUARD_EN
    S_PUSH_MDR = 4'd9,
    S_FAULT    = 4'd10
`else
    S_PUSH_MDR = 4'd9
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               take;

`ifdef STACK_GUARD_EN
  logic guard_fail;

  always_comb begin
    guard_fail = 1'b0;
    unique case (opcode)
      3'b000, 3'b001, 3'b010:  guard_fail = (depth_q < DEPTH_W'(2));
      3'b011, 3'b101, 3'b110:  guard_fail = (depth_q == '0);
      3'b100:                  guard_fail = (depth_q >= DEPTH_FULL);
      default:                 guard_fail = 1'b0;
    endcase
  end

  assign fault = (state_q == S_FAULT);
`else
  assign fault = 1'b0;
`endif

  assign take     = opcode[0] | (tos == {DATA_W{1'b0}});
  assign sp_depth = depth_q;

  // Strobes are gated by reset_n so an asserted reset silences them at once.
  always_comb begin
    state_d     = state_q;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    addr_src    = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    jump        = 1'b0;
    mdr_en      = 1'b0;
    load_a      = 1'b0;
    load_b      = 1'b0;
    alu_control = 2'b00;
    push        = 1'b0;
    pop         = 1'b0;
    stack_src   = 1'b0;
    instr_done  = 1'b0;
    if (reset_n) begin
      unique case (state_q)
        S_FETCH: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = S_DECODE;
          end
        end
        S_DECODE: begin
`ifdef STACK_GUARD_EN
          if (guard_fail) state_d = S_FAULT;
          else
`endif
          if (!opcode[2])                state_d = S_LOAD_A;
          else if (opcode[1])            state_d = S_JUMP;
          else if (opcode[0])            state_d = S_POP_WR;
          else                           state_d = S_LOAD_MDR;
        end
        S_LOAD_A: begin
          pop     = 1'b1;
          load_a  = 1'b1;
          state_d = (opcode == 3'b011) ? S_NOT_EX : S_LOAD_B;
        end
        S_LOAD_B: begin
          pop     = 1'b1;
          load_b  = 1'b1;
          state_d = S_OP2;
        end
        S_OP2: begin
          push        = 1'b1;
          alu_control = opcode[1:0];
          instr_done  = 1'b1;
          state_d     = S_FETCH;
        end
        S_NOT_EX: begin
          push        = 1'b1;
          alu_control = 2'b11;
          instr_done  = 1'b1;
          state_d     = S_FETCH;
        end
        S_JUMP: begin
          jump       = take;
          pc_write   = take;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_POP_WR: begin
          mem_write = 1'b1;
          addr_src  = 1'b1;
          if (mem_ready) begin
            pop        = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
        end
        S_LOAD_MDR: begin
          mem_read = 1'b1;
          addr_src = 1'b1;
          if (mem_ready) begin
            mdr_en  = 1'b1;
            state_d = S_PUSH_MDR;
          end
        end
        S_PUSH_MDR: begin
          push       = 1'b1;
          stack_src  = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
`ifdef STACK_GUARD_EN
        S_FAULT: state_d = S_FAULT;
`endif
        default: state_d = S_FETCH;
      endcase
    end
  end

  // Occupancy saturates at both ends rather than wrapping.
  always_comb begin
    depth_d = depth_q;
    if (push && (depth_q != DEPTH_FULL))
      depth_d = depth_q + DEPTH_ONE;
    else if (pop && (depth_q != '0))
      depth_d = depth_q - DEPTH_ONE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      depth_q <= '0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stack_ctrl_mc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_stack_ctrl_mc : randomized scoreboard bench for stack_ctrl_mc against an
// instruction-level model (latency, strobe counts, stack occupancy).
// Revision: 1.0
// ============================================================================
module tb_stack_ctrl_mc;

  localparam int DATA_W      = 8;
  localparam int STACK_DEPTH = 8;
  localparam int DEPTH_W     = $clog2(STACK_DEPTH + 1);

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic [2:0]         opcode = 3'b000;
  logic [DATA_W-1:0]  tos = '0;
  logic               mem_ready = 1'b0;
  logic               mem_read, mem_write, addr_src, ir_write, pc_write, jump;
  logic               mdr_en, load_a, load_b, push, pop, stack_src, instr_done, fault;
  logic [1:0]         alu_control;
  logic [DEPTH_W-1:0] sp_depth;

  stack_ctrl_mc #(.DATA_W(DATA_W), .STACK_DEPTH(STACK_DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .tos(tos), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .addr_src(addr_src), .ir_write(ir_write),
    .pc_write(pc_write), .jump(jump), .mdr_en(mdr_en), .load_a(load_a), .load_b(load_b),
    .alu_control(alu_control), .push(push), .pop(pop), .stack_src(stack_src),
    .sp_depth(sp_depth), .instr_done(instr_done), .fault(fault)
  );

  always #5 clk = ~clk;

  // Per-instruction summary: expected by the model, observed by the monitor.
  typedef struct {
    int lat; int pops; int pushes; int pcw; int irw; int jmp; int alu; int memc;
    int wr; int addr1; int mdr; int la; int lb; int ssrc; int dep; int op;
  } rec_t;

  rec_t exp_q[$];
  int   wait_q[$];
  int   checks = 0, failures = 0;
  int   model_depth = 0;
  int   issued = 0, done_cnt = 0;
  bit   aborted = 1'b0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int inc_sat(input int d);
    return (d < STACK_DEPTH) ? d + 1 : d;
  endfunction

  function automatic int dec_sat(input int d);
    return (d > 0) ? d - 1 : 0;
  endfunction

  // Memory responder: each access waits the queued number of cycles.
  initial begin : memory
    int  mcnt;
    bit  mhave;
    mcnt  = 0;
    mhave = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        mhave = 1'b0;
        mem_ready = 1'b0;
      end else if (mem_read || mem_write) begin
        if (!mhave) begin
          mcnt  = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
          mhave = 1'b1;
        end
        if (mcnt > 0) begin
          mem_ready = 1'b0;
          mcnt--;
        end else begin
          mem_ready = 1'b1;
          mhave = 1'b0;
        end
      end else begin
        mem_ready = 1'b0;
      end
    end
  end

  initial begin : monitor
    rec_t obs, e;
    obs = '{default:0};
    forever begin
      @(negedge clk);
      #1;
      if (!reset_n) begin
        obs = '{default:0};
        continue;
      end
      obs.lat++;
      if (obs.lat == 1 && exp_q.size() > 0)
        check("depth_at_fetch", int'(sp_depth), exp_q[0].dep);
      obs.pops   += int'(pop);
      obs.pushes += int'(push);
      obs.pcw    += int'(pc_write);
      obs.irw    += int'(ir_write);
      obs.memc   += int'(mem_read | mem_write);
      obs.wr     += int'(mem_write);
      obs.addr1  += int'(addr_src);
      obs.mdr    += int'(mdr_en);
      obs.la     += int'(load_a);
      obs.lb     += int'(load_b);
      obs.ssrc   += int'(push & stack_src);
      if (jump) obs.jmp = 1;
      if (push) obs.alu = int'(alu_control);
      if (push && pop) obs.op = 1;
      if (instr_done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("latency", obs.lat, e.lat);
          check("pop_count", obs.pops, e.pops);
          check("push_count", obs.pushes, e.pushes);
          check("pc_write_count", obs.pcw, e.pcw);
          check("ir_write_count", obs.irw, e.irw);
          check("jump_taken", obs.jmp, e.jmp);
          check("mem_cycles", obs.memc, e.memc);
          check("mem_write_cycles", obs.wr, e.wr);
          check("addr_src_cycles", obs.addr1, e.addr1);
          check("mdr_en_count", obs.mdr, e.mdr);
          check("load_a_count", obs.la, e.la);
          check("load_b_count", obs.lb, e.lb);
          check("stack_src_mdr", obs.ssrc, e.ssrc);
          check("push_pop_overlap", obs.op, 0);
          check("fault_flag", int'(fault), 0);
          if (e.alu >= 0) check("alu_control", obs.alu, e.alu);
        end
        obs = '{default:0};
        done_cnt++;
      end
    end
  end

  // Model one instruction from opcode semantics and queue its expectations.
  task automatic issue(input int op, input int tosv, input int wf, input int wd, input bit wait_done);
    rec_t e;
    int   take;
    e = '{default:0};
    e.dep = model_depth; e.memc = 1 + wf; e.pcw = 1; e.irw = 1; e.alu = -1;
    case (op)
      0, 1, 2: begin
        e.lat = 5 + wf; e.pops = 2; e.pushes = 1; e.alu = op; e.la = 1; e.lb = 1;
        model_depth = inc_sat(dec_sat(dec_sat(model_depth)));
      end
      3: begin
        e.lat = 4 + wf; e.pops = 1; e.pushes = 1; e.alu = 3; e.la = 1;
        model_depth = inc_sat(dec_sat(model_depth));
      end
      4: begin
        e.lat = 4 + wf + wd; e.pushes = 1; e.memc += 1 + wd; e.addr1 = 1 + wd;
        e.mdr = 1; e.ssrc = 1;
        model_depth = inc_sat(model_depth);
      end
      5: begin
        e.lat = 3 + wf + wd; e.pops = 1; e.memc += 1 + wd; e.wr = 1 + wd; e.addr1 = 1 + wd;
        model_depth = dec_sat(model_depth);
      end
      default: begin
        take  = (op == 7 || tosv == 0) ? 1 : 0;
        e.lat = 3 + wf; e.pcw = 1 + take; e.jmp = take;
      end
    endcase
    opcode = 3'(op);
    tos    = DATA_W'(tosv);
    wait_q.push_back(wf);
    if (op == 4 || op == 5) wait_q.push_back(wd);
    exp_q.push_back(e);
    issued++;
    if (wait_done) begin
      for (int k = 0; k < 200 && done_cnt < issued; k++) @(posedge clk);
      if (done_cnt < issued) begin
        check("instr_done_timeout", done_cnt, issued);
        aborted = 1'b1;
      end
      #1;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    exp_q.delete();
    wait_q.delete();
    model_depth = 0;
    issued = done_cnt;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
  endtask

  initial begin : stimulus
    int op, d, ok;
    bit popseen;
    #13;
    check("reset_outputs", int'({mem_read, mem_write, addr_src, ir_write, pc_write, jump, mdr_en,
          load_a, load_b, alu_control, push, pop, stack_src, instr_done, fault}), 0);
    check("reset_depth", int'(sp_depth), 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    check("fetch_mem_read", int'(mem_read), 1);
    check("fetch_addr_src", int'(addr_src), 0);

    issue(4, 0, 0, 0, 1);
    issue(4, 0, 0, 0, 1);
    issue(0, 0, 0, 0, 1);
    issue(7, 0, 3, 0, 1);
    issue(6, 8'h00, 0, 0, 1);
    issue(6, 8'h05, 0, 0, 1);
    issue(5, 0, 1, 2, 1);
    issue(3, 0, 0, 0, 1);

    for (int i = 0; i < 70 && !aborted; i++) begin
      op = $urandom_range(0, 7);
      d  = model_depth;
`ifdef STACK_GUARD_EN
      ok = (op <= 2) ? int'(d >= 2) : (op == 4) ? int'(d < STACK_DEPTH) :
           (op == 7) ? 1 : int'(d >= 1);
      if (ok == 0) op = (d < STACK_DEPTH) ? 4 : 7;
`else
      ok = d;
`endif
      issue(op, ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 255),
            ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3),
            ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3), 1);
    end

    // Abort a push while its data read is stalled.
    if (!aborted) begin
      issue(4, 0, 0, 6, 0);
      for (int k = 0; k < 30 && !(mem_read && addr_src); k++) begin
        @(negedge clk);
        #2;
      end
      check("reached_load_mdr_wait", int'(mem_read && addr_src), 1);
      reset_n = 1'b0;
      #1;
      check("async_reset_outputs", int'({mem_read, mem_write, addr_src, ir_write, pc_write, jump,
            mdr_en, load_a, load_b, alu_control, push, pop, stack_src, instr_done, fault}), 0);
      check("async_reset_depth", int'(sp_depth), 0);
      do_reset();
      check("post_reset_fetch", int'(mem_read && !addr_src), 1);
      issue(4, 0, 0, 0, 1);
      issue(5, 0, 0, 0, 1);
    end

`ifdef STACK_GUARD_EN
    if (!aborted) begin
      do_reset();
      issue(4, 0, 0, 0, 1);
      opcode = 3'b001;
      popseen = 1'b0;
      repeat (6) begin
        @(negedge clk);
        #2;
        popseen |= pop;
      end
      check("guard_fault_set", int'(fault), 1);
      check("guard_no_pop", int'(popseen), 0);
      check("guard_depth_kept", int'(sp_depth), 1);
      reset_n = 1'b0;
      #1;
      check("guard_fault_cleared", int'(fault), 0);
      do_reset();
    end
`else
    popseen = 1'b0;
    ok = 0;
`endif

    check("all_instructions_retired", done_cnt, issued);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
